// File: rtl/ula_seq_controle.sv
// Sequencer in front of the 4:1 result mux bank: it registers the operands, drives the mux
// select for a per-op settle time, captures the mux output and returns it by valid/ready.
module ula_seq_controle #(
  parameter int WIDTH   = 4,
  parameter int LAT_OP0 = 1,
  parameter int LAT_OP1 = 1,
  parameter int LAT_OP2 = 3,
  parameter int LAT_OP3 = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] opa_q,
  output logic [WIDTH-1:0] opb_q,
  output logic [1:0]       mux_sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; res_valid is high only in DONE, and res is stable while it is.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SET_W = 8;

  // A settle time of 0 is treated as 1, so the counter is always loaded with LAT-1.
  localparam int L0 = (LAT_OP0 < 1) ? 1 : LAT_OP0;
  localparam int L1 = (LAT_OP1 < 1) ? 1 : LAT_OP1;
  localparam int L2 = (LAT_OP2 < 1) ? 1 : LAT_OP2;
  localparam int L3 = (LAT_OP3 < 1) ? 1 : LAT_OP3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_d, opb_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] opcnt_q, opcnt_d;
  logic [SET_W-1:0] load_val;

  always_comb begin
    load_val = SET_W'(L0 - 1);
    case (in_op)
      2'b00:   load_val = SET_W'(L0 - 1);
      2'b01:   load_val = SET_W'(L1 - 1);
      2'b10:   load_val = SET_W'(L2 - 1);
      default: load_val = SET_W'(L3 - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sel_d   = sel_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    opcnt_d = opcnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d   = in_a;
          opb_d   = in_b;
          sel_d   = in_op;
          cnt_d   = load_val;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_d   = mux_y;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          opcnt_d = opcnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      opcnt_q <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      opcnt_q <= opcnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign mux_sel   = sel_q;
  assign res       = res_q;
  assign op_count  = opcnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ula_seq_controle.sv
// Directed bench for ula_seq_controle with a behavioural model of the mux bank
// (D0=a&b, D1=a|b, D2=a+b, D3=a^b) and a second instance with LAT_OP0=0.
module tb_ula_seq_controle;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- main DUT ----------------
  logic       in_valid, in_ready, res_valid, res_ready, busy;
  logic [1:0] in_op, mux_sel, state_dbg;
  logic [3:0] in_a, in_b, opa_q, opb_q, mux_y, res;
  logic [7:0] op_count;

  // ---------------- LAT_OP0=0 instance ----------------
  logic       in_valid_z, in_ready_z, res_valid_z, res_ready_z, busy_z;
  logic [1:0] in_op_z, mux_sel_z, state_dbg_z;
  logic [3:0] in_a_z, in_b_z, opa_q_z, opb_q_z, mux_y_z, res_z;
  logic [7:0] op_count_z;

  function automatic logic [3:0] mux_model(input logic [1:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a + b;
      default: return a ^ b;
    endcase
  endfunction

  assign mux_y   = mux_model(mux_sel, opa_q, opb_q);
  assign mux_y_z = mux_model(mux_sel_z, opa_q_z, opb_q_z);

  ula_seq_controle #(.WIDTH(4), .LAT_OP0(1), .LAT_OP1(1), .LAT_OP2(3), .LAT_OP3(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .opa_q(opa_q), .opb_q(opb_q), .mux_sel(mux_sel), .mux_y(mux_y),
    .res(res), .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .op_count(op_count),
    .state_dbg(state_dbg)
  );

  ula_seq_controle #(.WIDTH(4), .LAT_OP0(0), .LAT_OP1(1), .LAT_OP2(3), .LAT_OP3(2), .CNT_W(8)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_z), .in_ready(in_ready_z), .in_op(in_op_z),
    .in_a(in_a_z), .in_b(in_b_z), .opa_q(opa_q_z), .opb_q(opb_q_z), .mux_sel(mux_sel_z), .mux_y(mux_y_z),
    .res(res_z), .res_valid(res_valid_z), .res_ready(res_ready_z), .busy(busy_z), .op_count(op_count_z),
    .state_dbg(state_dbg_z)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];
  logic [7:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request with res_ready high; returns cycles from request to res_valid
  // (accept cycle included) and ends one edge after the result handshake.
  task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input string tag, output int lat);
    logic [3:0] e;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; res_ready = 1'b1;
    exp_q.push_back(mux_model(op, a, b));
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
      check({tag, "_sel_held"}, mux_sel, op);
    end while (!res_valid && lat < 50);
    e = exp_q.pop_front();
    check({tag, "_res"}, res, e);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    check({tag, "_vld_drop"}, res_valid, 1'b0);
  endtask

  int lat;
  int n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; res_ready = 1'b0;
    in_valid_z = 1'b0; in_op_z = 2'b00; in_a_z = '0; in_b_z = '0; res_ready_z = 1'b0;
    exp_cnt = 8'd0;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_res", res, 4'h0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_mux_sel", mux_sel, 2'b00);
    check("rst_op_count", op_count, 8'd0);
    check("rst_state", state_dbg, 2'd0);

    // 5. reset during EXEC of op 10 (done first so op_count is 0 either way)
    in_valid = 1'b1; in_op = 2'b10; in_a = 4'h7; in_b = 4'h5; res_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("abort_pre_vld", res_valid, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_vld", res_valid, 1'b0);
    check("abort_busy_low", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_op_count", op_count, 8'd0);
    check("abort_mux_sel", mux_sel, 2'b00);
    check("abort_opa", opa_q, 4'h0);
    @(posedge clk); #1;
    check("abort_vld_later", res_valid, 1'b0);
    check("abort_idle_later", busy, 1'b0);

    // 2. op 10: 7+5 = C, latency LAT_OP2+1
    run_op(2'b10, 4'h7, 4'h5, "add", lat);
    check("add_latency", lat, 4);
    check("add_op_count", op_count, exp_cnt);

    // 3. op 00 with downstream stall; extra request during stall is ignored
    in_valid = 1'b1; in_op = 2'b00; in_a = 4'hA; in_b = 4'h6; res_ready = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      in_valid = 1'b0;
    end while (!res_valid && n < 20);
    check("stall_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; in_op = 2'b11; in_a = 4'hF; in_b = 4'h1;
      end
      check("stall_res", res, 4'h2);
      check("stall_vld", res_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_sel", mux_sel, 2'b00);
      check("stall_opa", opa_q, 4'hA);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_still_vld", res_valid, 1'b1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    check("stall_vld_drop", res_valid, 1'b0);
    check("stall_op_count", op_count, exp_cnt);
    @(posedge clk); #1;
    check("stall_no_accept", busy, 1'b0);
    check("stall_op_count_hold", op_count, exp_cnt);

    // 4. back-to-back 01 then 11 with in_valid held
    in_valid = 1'b1; in_op = 2'b01; in_a = 4'hA; in_b = 4'h6; res_ready = 1'b1;
    @(posedge clk); #1;
    check("b2b_busy1", busy, 1'b1);
    in_op = 2'b11;
    @(posedge clk); #1;
    check("b2b_vld1", res_valid, 1'b1);
    check("b2b_res1", res, 4'hE);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    check("b2b_idle_gap", busy, 1'b0);
    check("b2b_ready_gap", in_ready, 1'b1);
    check("b2b_count1", op_count, exp_cnt);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_accept2", busy, 1'b1);
    check("b2b_sel2", mux_sel, 2'b11);
    @(posedge clk); #1;
    check("b2b_exec2", res_valid, 1'b0);
    @(posedge clk); #1;
    check("b2b_vld2", res_valid, 1'b1);
    check("b2b_res2", res, 4'hC);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    check("b2b_count2", op_count, exp_cnt);

    // 6. op_count wrap
    while (exp_cnt != 8'd255) run_op(2'b00, 4'hF, 4'h3, "fill", lat);
    check("wrap_pre", op_count, 8'd255);
    run_op(2'b00, 4'hF, 4'h3, "wrap", lat);
    check("wrap_lat", lat, 2);
    check("wrap_zero", op_count, 8'd0);

    // LAT_OP0=0 behaves like LAT_OP0=1
    in_valid_z = 1'b1; in_op_z = 2'b00; in_a_z = 4'hC; in_b_z = 4'hA; res_ready_z = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      in_valid_z = 1'b0;
    end while (!res_valid_z && n < 20);
    check("lat0_latency", n, 2);
    check("lat0_res", res_z, 4'h8);
    @(posedge clk); #1;
    check("lat0_count", op_count_z, 8'd1);
    check("lat0_idle", busy_z, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
